// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with clamped load, one-shot halt and cascade tc.
// Define COUNTER_BCD_OUT_EN to add the registered BCD digit outputs.
module modn_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 199,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
`ifdef COUNTER_BCD_OUT_EN
  ,
  output logic [3:0]       bcd_ones,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_hundreds
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  if (longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1) ||
      MAX_COUNT < 0) begin : g_bad_max
    $error("MAX_COUNT out of range for WIDTH");
  end
  if (RESET_VALUE > MAX_COUNT || RESET_VALUE < 0) begin : g_bad_rst
    $error("RESET_VALUE out of range");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             terminal;

  assign terminal = up ? (cnt_q == MAX_V) : (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (load) begin
      cnt_d   = (load_value > MAX_V) ? MAX_V : load_value;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && en) begin
      if (terminal) begin
        if (one_shot) begin
          done_d  = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = up ? '0 : MAX_V;
        end
      end else begin
        cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= RST_V;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Held low during reset so a cascaded stage never sees a spurious carry.
  assign tc   = ~rst & en & ~load & (state_q == RUN) & terminal;
  assign q    = cnt_q;
  assign done = done_q;

`ifdef COUNTER_BCD_OUT_EN
  if (MAX_COUNT > 999) begin : g_bad_bcd
    $error("BCD output requires MAX_COUNT <= 999");
  end

  function automatic logic [11:0] bin2bcd(input logic [WIDTH-1:0] b);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < 3; d++) begin
        if (bcd[4*d +: 4] > 4'd4) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[10:0], b[i]};
    end
    return bcd;
  endfunction

  logic [11:0] bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcd_q <= bin2bcd(RST_V);
    else     bcd_q <= bin2bcd(cnt_q);
  end

  assign bcd_ones     = bcd_q[3:0];
  assign bcd_tens     = bcd_q[7:4];
  assign bcd_hundreds = bcd_q[11:8];
`endif

endmodule
